// File: rtl/fp_add_result_pack.sv
// FP adder final stage: IEEE special-case select, result packing,
// 2-entry skid buffer and sticky overflow/invalid status.
module fp_add_result_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_z,
  input  logic [EXP_W-1:0] exp_z,
  input  logic [MAN_W-1:0] man_z,
  input  logic             sign_x,
  input  logic             sign_y,
  input  logic             overflow_case,
  input  logic             x_is_inf,
  input  logic             y_is_inf,
  input  logic             x_is_nan,
  input  logic             y_is_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic             res_ovf,
  output logic             res_inv,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic             sticky_inv
);

  localparam int W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         inv;
  } entry_t;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;
  localparam logic [MAN_W-1:0] MAN_QBIT =
    MAN_W'(1) << (MAN_W - 1);

  entry_t       r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         r_in_ready;
  logic         r_sticky_ovf;
  logic         r_sticky_inv;

  entry_t       w_new;
  entry_t       w_head;
  logic         w_push;
  logic         w_pop;
  logic         w_out_valid;
  logic [1:0]   w_cnt_nxt;
  logic [W-1:0] w_qnan;

  assign w_qnan = {1'b0, EXP_ONES, MAN_QBIT};

  // NaN beats inf-inf, which beats single inf, which beats overflow
  always_comb begin
    w_new.res = {sign_z, exp_z, man_z};
    w_new.ovf = 1'b0;
    w_new.inv = 1'b0;
    if (x_is_nan | y_is_nan) begin
      w_new.res = w_qnan;
    end else if (x_is_inf & y_is_inf & (sign_x ^ sign_y)) begin
      w_new.res = w_qnan;
      w_new.inv = 1'b1;
    end else if (x_is_inf) begin
      w_new.res = {sign_x, EXP_ONES, MAN_ZERO};
    end else if (y_is_inf) begin
      w_new.res = {sign_y, EXP_ONES, MAN_ZERO};
    end else if (overflow_case) begin
      w_new.res = {sign_z, EXP_ONES, MAN_ZERO};
      w_new.ovf = 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd];
  assign w_out_valid = (r_cnt != 2'd0);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;
  assign w_cnt_nxt   = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_new;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt != 2'd2);
    end
  end

  // a set in the clearing cycle survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_inv <= 1'b0;
    end else if (clr_sticky) begin
      r_sticky_ovf <= w_pop & w_head.ovf;
      r_sticky_inv <= w_pop & w_head.inv;
    end else begin
      r_sticky_ovf <= r_sticky_ovf | (w_pop & w_head.ovf);
      r_sticky_inv <= r_sticky_inv | (w_pop & w_head.inv);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign result     = w_head.res;
  assign res_ovf    = w_head.ovf;
  assign res_inv    = w_head.inv;
  assign sticky_ovf = r_sticky_ovf;
  assign sticky_inv = r_sticky_inv;

endmodule

// File: tb/tb_fp_add_result_pack.sv
// Directed-vector bench for fp_add_result_pack:
// special-case select, skid buffer ordering, stickies, reset flush.
module tb_fp_add_result_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_z;
  logic [7:0]  exp_z;
  logic [22:0] man_z;
  logic        sign_x;
  logic        sign_y;
  logic        overflow_case;
  logic        x_is_inf;
  logic        y_is_inf;
  logic        x_is_nan;
  logic        y_is_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        res_ovf;
  logic        res_inv;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic        sticky_inv;

  int n_vec = 0;
  int n_bad = 0;

  fp_add_result_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_z(sign_z), .exp_z(exp_z), .man_z(man_z),
    .sign_x(sign_x), .sign_y(sign_y),
    .overflow_case(overflow_case),
    .x_is_inf(x_is_inf), .y_is_inf(y_is_inf),
    .x_is_nan(x_is_nan), .y_is_nan(y_is_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_ovf(res_ovf), .res_inv(res_inv),
    .clr_sticky(clr_sticky),
    .sticky_ovf(sticky_ovf), .sticky_inv(sticky_inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sum(input logic sz,
                         input logic [7:0] ez,
                         input logic [22:0] mz);
    sign_z = sz; exp_z = ez; man_z = mz;
    sign_x = 1'b0; sign_y = 1'b0;
    overflow_case = 1'b0;
    x_is_inf = 1'b0; y_is_inf = 1'b0;
    x_is_nan = 1'b0; y_is_nan = 1'b0;
  endtask

  // push one vector into an empty buffer, check it, then pop it
  task automatic one(input string tag,
                     input logic [31:0] e_res,
                     input logic e_ovf,
                     input logic e_inv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".res"}, result, e_res);
    chk({tag, ".ovf"}, {31'd0, res_ovf}, {31'd0, e_ovf});
    chk({tag, ".inv"}, {31'd0, res_inv}, {31'd0, e_inv});
    tick();
    chk({tag, ".pop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    set_sum(1'b0, 8'h00, 23'h0);
    #12;
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    chk("rst.res", result, 32'h0);
    chk("rst.stk", {30'd0, sticky_ovf, sticky_inv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    // T1 normal sum
    set_sum(1'b0, 8'h80, 23'h0);
    one("t1", 32'h4000_0000, 1'b0, 1'b0);

    // T2 inf - inf
    set_sum(1'b0, 8'h10, 23'h5);
    x_is_inf = 1'b1; y_is_inf = 1'b1;
    sign_x = 1'b0; sign_y = 1'b1;
    one("t2", 32'h7FC0_0000, 1'b0, 1'b1);
    chk("t2.sinv", {31'd0, sticky_inv}, 32'd1);
    chk("t2.sovf", {31'd0, sticky_ovf}, 32'd0);

    // T3 overflow
    set_sum(1'b1, 8'hFE, 23'h7FFFFF);
    overflow_case = 1'b1;
    one("t3o", 32'hFF80_0000, 1'b1, 1'b0);
    chk("t3.sovf", {31'd0, sticky_ovf}, 32'd1);

    // NaN beats every other flag
    set_sum(1'b1, 8'hFE, 23'h1);
    x_is_nan = 1'b1; overflow_case = 1'b1;
    x_is_inf = 1'b1; y_is_inf = 1'b1;
    sign_x = 1'b0; sign_y = 1'b1;
    one("t3n", 32'h7FC0_0000, 1'b0, 1'b0);
    set_sum(1'b0, 8'h01, 23'h1);
    y_is_nan = 1'b1;
    one("t3y", 32'h7FC0_0000, 1'b0, 1'b0);

    // single infinities, same-sign inf+inf, inf over overflow
    set_sum(1'b0, 8'h33, 23'h0);
    x_is_inf = 1'b1; sign_x = 1'b1; overflow_case = 1'b1;
    one("xinf", 32'hFF80_0000, 1'b0, 1'b0);
    set_sum(1'b1, 8'h33, 23'h0);
    y_is_inf = 1'b1; sign_y = 1'b0;
    one("yinf", 32'h7F80_0000, 1'b0, 1'b0);
    set_sum(1'b1, 8'h33, 23'h0);
    x_is_inf = 1'b1; y_is_inf = 1'b1;
    sign_x = 1'b1; sign_y = 1'b1;
    one("iinf", 32'hFF80_0000, 1'b0, 1'b0);

    // clear with no pop
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr.stk", {30'd0, sticky_ovf, sticky_inv}, 32'd0);

    // T5 set wins over clear
    set_sum(1'b0, 8'hFF, 23'h0);
    overflow_case = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t5.set", {31'd0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t5.clr", {31'd0, sticky_ovf}, 32'd0);

    // T4 backpressure, three back-to-back pushes
    out_ready = 1'b0;
    set_sum(1'b0, 8'h7F, 23'h0);
    in_valid = 1'b1;
    tick();
    chk("t4.rdy1", {31'd0, in_ready}, 32'd1);
    set_sum(1'b1, 8'h81, 23'h400000);
    tick();
    chk("t4.rdy2", {31'd0, in_ready}, 32'd0);
    chk("t4.hdA", result, 32'h3F80_0000);
    set_sum(1'b0, 8'h01, 23'h000001);
    tick();
    chk("t4.hold", {31'd0, in_ready}, 32'd0);
    chk("t4.hdA2", result, 32'h3F80_0000);
    out_ready = 1'b1;
    tick();
    chk("t4.hdB", result, 32'hC0C0_0000);
    chk("t4.rdy3", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4.hdC", result, 32'h0080_0001);
    chk("t4.vldC", {31'd0, out_valid}, 32'd1);
    tick();
    chk("t4.empty", {31'd0, out_valid}, 32'd0);

    // T6 reset with two entries buffered
    out_ready = 1'b0;
    set_sum(1'b0, 8'h90, 23'h0);
    in_valid = 1'b1;
    tick();
    set_sum(1'b0, 8'h91, 23'h0);
    tick();
    in_valid = 1'b0;
    chk("t6.full", {30'd0, out_valid, in_ready}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.vld", {31'd0, out_valid}, 32'd0);
    chk("t6.rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    set_sum(1'b1, 8'h40, 23'h123456);
    one("t6n", 32'hA012_3456, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
